tim_ctrl: RTL and testbench

//  Sequencer for the prescaled timer datapath: programmable prescaler tick plus compare-match timer.

---
 rtl/tim_ctrl_pkg.sv | 17 +
 rtl/tim_ctrl_presc.sv | 39 +++
 rtl/tim_ctrl.sv | 168 ++++++++++++++++
 tb/tb_tim_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tim_ctrl_pkg.sv
// Shared encodings and default widths for the prescaled compare-match timer.
// Imported by tim_ctrl and tim_ctrl_presc.
package tim_ctrl_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int PRE_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tim_ctrl_presc.sv
// Programmable prescaler: counts 0..div while enabled and strobes tick on the
// terminal count, so tick repeats every div+1 enabled cycles.
module tim_ctrl_presc
    import tim_ctrl_pkg::*;
#(
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] div,
    output logic             tick
);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    // tick is a pure decode of the counter register, never of clr
    assign tick = en && (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tim_ctrl.sv
// Timer sequencer: IDLE/RUN/DONE FSM, config shadows, compare-match timer,
// expire pulse and sticky irq. Optional capture path under TIM_CTRL_CAPTURE_EN.
module tim_ctrl
    import tim_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [PRE_W-1:0] pre_div,
    input  logic [CNT_W-1:0] cmp,
    input  logic             irq_clr,
    input  logic             cap_in,
    output logic             busy,
    output logic             tick,
    output logic [CNT_W-1:0] tim,
    output logic             expire,
    output logic             irq,
    output logic [CNT_W-1:0] cap_val,
    output logic             cap_vld
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [PRE_W-1:0] pre_div_q, pre_div_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [CNT_W-1:0] tim_q, tim_d;
    logic             expire_q, expire_d;
    logic             irq_q, irq_d;
    logic             presc_clr;
    logic             presc_en;
    logic             presc_tick;

    assign presc_en = (state_q == ST_RUN);

    tim_ctrl_presc #(
        .PRE_W (PRE_W)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .div  (pre_div_q),
        .tick (presc_tick)
    );

    // Stop outranks a same-cycle tick, so a stopped run can never expire
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pre_div_d = pre_div_q;
        cmp_d     = cmp_q;
        tim_d     = tim_q;
        expire_d  = 1'b0;
        presc_clr = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mode_d    = mode;
                    pre_div_d = pre_div;
                    cmp_d     = cmp;
                    tim_d     = '0;
                    presc_clr = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    presc_clr = 1'b1;
                    state_d   = ST_IDLE;
                end else if (presc_tick) begin
                    if (tim_q == cmp_q) begin
                        expire_d = 1'b1;
                        if (mode_q == MODE_PERIODIC) begin
                            tim_d = '0;
                        end else begin
                            presc_clr = 1'b1;
                            state_d   = ST_DONE;
                        end
                    end else begin
                        tim_d = tim_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // irq follows the registered expire pulse; a set beats a coincident clear
    always_comb begin
        irq_d = irq_q;
        if (expire_q) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            pre_div_q <= '0;
            cmp_q     <= '0;
            tim_q     <= '0;
            expire_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pre_div_q <= pre_div_d;
            cmp_q     <= cmp_d;
            tim_q     <= tim_d;
            expire_q  <= expire_d;
            irq_q     <= irq_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign tick   = presc_tick;
    assign tim    = tim_q;
    assign expire = expire_q;
    assign irq    = irq_q;

`ifdef TIM_CTRL_CAPTURE_EN
    logic             cap_in_q;
    logic [CNT_W-1:0] cap_val_q, cap_val_d;
    logic             cap_vld_q, cap_vld_d;

    // A rising edge seen while running snapshots the timer of that same cycle
    always_comb begin
        cap_val_d = cap_val_q;
        cap_vld_d = 1'b0;
        if ((state_q == ST_RUN) && cap_in && !cap_in_q) begin
            cap_val_d = tim_q;
            cap_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_in_q  <= 1'b0;
            cap_val_q <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            cap_in_q  <= cap_in;
            cap_val_q <= cap_val_d;
            cap_vld_q <= cap_vld_d;
        end
    end

    assign cap_val = cap_val_q;
    assign cap_vld = cap_vld_q;
`else
    logic unused_cap_in;

    assign unused_cap_in = cap_in;
    assign cap_val       = '0;
    assign cap_vld       = 1'b0;
`endif

endmodule

// File: tb/tb_tim_ctrl.sv
// Self-checking bench for tim_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an arithmetic timer model.
module tb_tim_ctrl;
    import tim_ctrl_pkg::*;

    localparam int CNT_W = 4;
    localparam int PRE_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             mode;
    logic [PRE_W-1:0] pre_div;
    logic [CNT_W-1:0] cmp;
    logic             irq_clr;
    logic             cap_in;
    logic             busy;
    logic             tick;
    logic [CNT_W-1:0] tim;
    logic             expire;
    logic             irq;
    logic [CNT_W-1:0] cap_val;
    logic             cap_vld;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    tim_ctrl #(
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .pre_div (pre_div),
        .cmp     (cmp),
        .irq_clr (irq_clr),
        .cap_in  (cap_in),
        .busy    (busy),
        .tick    (tick),
        .tim     (tim),
        .expire  (expire),
        .irq     (irq),
        .cap_val (cap_val),
        .cap_vld (cap_vld)
    );

    always #5 clk = ~clk;

    // Model: a run is described only by the number of edges since start, n.
    // prescaler phase = n mod (P+1); timer = floor(n/(P+1)) mod (C+1);
    // expire lands on every edge where n is a multiple of (C+1)*(P+1).
    bit m_run;
    bit m_mode;
    int m_p;
    int m_c;
    int m_n;
    int m_hold;
    bit m_expire;
    bit m_irq;
    int m_cap_val;
    bit m_cap_vld;
    bit m_cap_prev;

    function automatic int m_tim();
        return m_run ? (m_n / (m_p + 1)) % (m_c + 1) : m_hold;
    endfunction

    function automatic bit m_tick();
        return m_run && ((m_n % (m_p + 1)) == m_p);
    endfunction

    always @(posedge clk) begin : model_update
        int tnow;
        bit nexp;
        bit irq_n;
        tnow = m_tim();
        nexp = 1'b0;
        if (rst) begin
            m_run = 0; m_mode = 0; m_p = 0; m_c = 0; m_n = 0; m_hold = 0;
            m_expire = 0; m_irq = 0; m_cap_val = 0; m_cap_vld = 0; m_cap_prev = 0;
        end else begin
            irq_n = m_expire ? 1'b1 : (irq_clr ? 1'b0 : m_irq);
`ifdef TIM_CTRL_CAPTURE_EN
            if (m_run && cap_in && !m_cap_prev) begin
                m_cap_val = tnow;
                m_cap_vld = 1'b1;
            end else begin
                m_cap_vld = 1'b0;
            end
            m_cap_prev = cap_in;
`endif
            if (m_run) begin
                if (stop) begin
                    m_hold = tnow;
                    m_run  = 1'b0;
                end else begin
                    m_n++;
                    if ((m_n % ((m_c + 1) * (m_p + 1))) == 0) begin
                        nexp = 1'b1;
                        if (m_mode == MODE_ONESHOT) begin
                            m_run  = 1'b0;
                            m_hold = m_c;
                        end
                    end
                end
            end else if (start) begin
                m_mode = mode;
                m_p    = int'(pre_div);
                m_c    = int'(cmp);
                m_n    = 0;
                m_run  = 1'b1;
            end
            m_expire = nexp;
            m_irq    = irq_n;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("m_tim",     32'(tim),     32'(m_tim()));
            checkOutput("m_busy",    32'(busy),    32'(m_run));
            checkOutput("m_tick",    32'(tick),    32'(m_tick()));
            checkOutput("m_expire",  32'(expire),  32'(m_expire));
            checkOutput("m_irq",     32'(irq),     32'(m_irq));
            checkOutput("m_cap_val", 32'(cap_val), 32'(m_cap_val));
            checkOutput("m_cap_vld", 32'(cap_vld), 32'(m_cap_vld));
        end
    end

    task automatic applyStimulus(input bit s, input bit sp, input bit ic, input bit ci, input bit r);
        start   = s;
        stop    = sp;
        irq_clr = ic;
        cap_in  = ci;
        rst     = r;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic setCfg(input bit md, input int pd, input int cv);
        mode    = md;
        pre_div = PRE_W'(pd);
        cmp     = CNT_W'(cv);
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; irq_clr = 0; cap_in = 0;
        setCfg(0, 0, 0);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        checkOutput("rst_busy",   32'(busy),   0);
        checkOutput("rst_tim",    32'(tim),    0);
        checkOutput("rst_irq",    32'(irq),    0);
        checkOutput("rst_expire", 32'(expire), 0);
        checkOutput("rst_capvld", 32'(cap_vld), 0);

        // one-shot, pre_div=0, cmp=3
        setCfg(0, 0, 3);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t1_busy", 32'(busy), 1);
        checkOutput("t1_tim0", 32'(tim), 0);
        idle(3);
        checkOutput("t1_noexp", 32'(expire), 0);
        idle(1);
        checkOutput("t1_expire", 32'(expire), 1);
        checkOutput("t1_done",   32'(busy), 0);
        checkOutput("t1_hold",   32'(tim), 3);
        idle(1);
        checkOutput("t1_irq",    32'(irq), 1);
        checkOutput("t1_pulse",  32'(expire), 0);

        // periodic, pre_div=2, cmp=1; config changed mid-run must not matter
        setCfg(1, 2, 1);
        applyStimulus(1, 0, 0, 0, 0);
        setCfg(0, 7, 9);
        checkOutput("t2_tick0", 32'(tick), 0);
        idle(2);
        checkOutput("t2_tick2", 32'(tick), 1);
        checkOutput("t2_tim2",  32'(tim), 0);
        idle(1);
        checkOutput("t2_tim3",  32'(tim), 1);
        idle(3);
        checkOutput("t2_exp6",  32'(expire), 1);
        checkOutput("t2_tim6",  32'(tim), 0);
        idle(6);
        checkOutput("t2_exp12", 32'(expire), 1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t2_stop",  32'(busy), 0);

        // stop mid-run, then start+stop priority
        applyStimulus(0, 0, 1, 0, 0);
        setCfg(0, 0, 9);
        applyStimulus(1, 0, 0, 0, 0);
        idle(5);
        checkOutput("t3_tim5", 32'(tim), 5);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t3_busy", 32'(busy), 0);
        checkOutput("t3_hold", 32'(tim), 5);
        idle(3);
        checkOutput("t3_hold3", 32'(tim), 5);
        checkOutput("t3_noexp", 32'(expire), 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t3_startwins", 32'(busy), 1);
        checkOutput("t3_restart",   32'(tim), 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t3_stopwins", 32'(busy), 0);
        checkOutput("t3_stoptim",  32'(tim), 0);

        // irq_clr coincident with expire
        setCfg(1, 0, 1);
        applyStimulus(1, 0, 0, 0, 0);
        idle(2);
        checkOutput("t4_exp1", 32'(expire), 1);
        idle(2);
        checkOutput("t4_exp2", 32'(expire), 1);
        checkOutput("t4_irq",  32'(irq), 1);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("t4_setwins", 32'(irq), 1);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("t4_clr",    32'(irq), 0);
        checkOutput("t4_noexp",  32'(expire), 0);

        // reset mid-run
        setCfg(1, 0, 3);
        applyStimulus(1, 0, 0, 0, 0);
        idle(6);
        checkOutput("t5_tim2", 32'(tim), 2);
        checkOutput("t5_irq1", 32'(irq), 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t5_busy", 32'(busy), 0);
        checkOutput("t5_tim",  32'(tim), 0);
        checkOutput("t5_irq",  32'(irq), 0);
        checkOutput("t5_tick", 32'(tick), 0);
        applyStimulus(1, 0, 0, 0, 0);
        idle(1);
        checkOutput("t5_restart", 32'(tim), 1);

        // capture
        applyStimulus(0, 1, 0, 0, 0);
        setCfg(0, 0, 9);
        applyStimulus(1, 0, 0, 0, 0);
        idle(2);
        applyStimulus(0, 0, 0, 1, 0);
`ifdef TIM_CTRL_CAPTURE_EN
        checkOutput("t6_capval", 32'(cap_val), 2);
        checkOutput("t6_capvld", 32'(cap_vld), 1);
`else
        checkOutput("t6_capval", 32'(cap_val), 0);
        checkOutput("t6_capvld", 32'(cap_vld), 0);
`endif
        idle(1);
        checkOutput("t6_pulse", 32'(cap_vld), 0);
        applyStimulus(0, 1, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                setCfg(1'($urandom_range(0, 1)),
                       ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2)),
                       ($urandom_range(0, 5) == 0) ? 15 : int'($urandom_range(0, 5)));
            end
            applyStimulus($urandom_range(0, 9) == 0,
                          $urandom_range(0, 39) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
